fir_serial_out_sink: RTL and testbench

Output-side companion to the team's fully serial 8-tap FIR. It tracks the filter's frame phase and captures the filter's 33-bit sfix33_En31 result once per frame. Each captured result is requantised to sfix16_En15 with round-half-up and saturation, then buffered in a small FIFO. Downstream logic reads it through a valid/ready stream, and the block keeps saturation and overflow status.

---
 rtl/fir_serial_out_sink.sv | 79 +++++++
 tb/tb_fir_serial_out_sink.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fir_serial_out_sink.sv
// fir_serial_out_sink: frame-aligned capture, requantise to sfix16_En15, FIFO stream out with saturation/overflow status
module fir_serial_out_sink #(
  parameter int FRAME_LEN = 8,
  parameter int DEPTH = 4,
  parameter int SATCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [32:0]         filter_out,
  output logic [15:0]         dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overflow,
  output logic                sat_flag,
  output logic [SATCNT_W-1:0] sat_count,
  input  logic                clear_status
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] n_q, n_d;
  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];
  logic ovf_q, ovf_d, sat_q, sat_d;
  logic [SATCNT_W-1:0] satn_q, satn_d;
  logic [33:0] t;
  logic [17:0] q;
  logic [15:0] res;
  logic sat_hi, sat_lo, sat, capture, pop, full, wr_en;
  always_comb begin
    t = {filter_out[32], filter_out} + 34'd32768;
    q = t[33:16];
    sat_hi = !q[17] && |q[16:15];
    sat_lo = q[17] && !(&q[16:15]);
    sat = sat_hi || sat_lo;
    res = sat_hi ? 16'h7fff : sat_lo ? 16'h8000 : q[15:0];
    capture = clk_enable && cnt_q == '0;
    pop = dout_valid && dout_ready;
    full = n_q == (AW+1)'(DEPTH);
    wr_en = capture && (!full || pop);
    cnt_d = clk_enable ? cnt_q + 1'b1 : cnt_q;
    wr_d = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    n_d = n_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = res;
    ovf_d = !clear_status && (ovf_q || (capture && full && !pop));
    sat_d = !clear_status && (sat_q || (capture && sat));
    satn_d = clear_status ? '0 : (capture && sat && satn_q != '1) ? satn_q + 1'b1 : satn_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CW'(FRAME_LEN - 1);
      wr_q <= '0;
      rd_q <= '0;
      n_q <= '0;
      mem_q <= '{default: '0};
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
      satn_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      n_q <= n_d;
      mem_q <= mem_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
      satn_q <= satn_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign dout_valid = n_q != '0;
  assign overflow = ovf_q;
  assign sat_flag = sat_q;
  assign sat_count = satn_q;
endmodule

// File: tb/tb_fir_serial_out_sink.sv
// tb_fir_serial_out_sink: random and directed stimulus against a queue-based reference model
module tb_fir_serial_out_sink;
  logic clk = 0, rst = 1, en = 0, ready = 0, clr = 0;
  logic [32:0] fo = '0;
  logic [15:0] dout;
  logic dout_valid, overflow, sat_flag;
  logic [15:0] sat_count;
  int n_chk = 0, n_fail = 0;
  int mcnt = 7;
  logic [15:0] mq[$];
  bit movf = 0, msat = 0;
  int msatn = 0;

  fir_serial_out_sink #(.FRAME_LEN(8), .DEPTH(4), .SATCNT_W(16)) dut (
    .clk(clk), .reset(rst), .clk_enable(en), .filter_out(fo), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(ready), .overflow(overflow),
    .sat_flag(sat_flag), .sat_count(sat_count), .clear_status(clr)
  );

  always #5 clk = ~clk;

  function automatic void rq(input logic [32:0] x, output logic [15:0] r, output bit s);
    longint v, q;
    v = longint'($signed(x)) + 64'sd32768;
    q = v / 65536;
    if (v % 65536 != 0 && v < 0) q -= 1;
    s = q > 32767 || q < -32768;
    r = q > 32767 ? 16'h7fff : q < -32768 ? 16'h8000 : 16'(q);
  endfunction

  task automatic tick();
    bit cap, pp, s;
    logic [15:0] r;
    cap = en && mcnt == 0;
    pp = mq.size() != 0 && ready;
    rq(fo, r, s);
    if (rst) begin
      mcnt = 7; mq.delete(); movf = 0; msat = 0; msatn = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < 4) mq.push_back(r);
        else movf = 1;
        if (s) begin msat = 1; if (msatn < 65535) msatn++; end
      end
      if (clr) begin movf = 0; msat = 0; msatn = 0; end
      if (en) mcnt = (mcnt + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_chk++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
    n_chk++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_sat_count got %0d want 0", sat_count); end
  endtask

  task automatic test_stream();
    int first = -1, pulses = 0;
    en = 1; ready = 1; fo = 33'h0_4000_0000;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (dout_valid === 1'b1) begin pulses++; if (first < 0) first = i; end
      n_chk++; if (dout_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b want %b", i, dout_valid, mq.size() != 0); end
      if (dout_valid === 1'b1) begin
        n_chk++; if (dout !== 16'h4000) begin n_fail++; $display("FAIL stream_dout got %h want 4000", dout); end
      end
    end
    n_chk++; if (first !== 2) begin n_fail++; $display("FAIL stream_first_valid got %0d want 2", first); end
    n_chk++; if (pulses !== 3) begin n_fail++; $display("FAIL stream_pulses got %0d want 3", pulses); end
    n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL stream_sat got %b want 0", sat_flag); end
  endtask

  task automatic run_table(input logic [32:0] v [], input logic [15:0] e [], input string nm);
    int seen;
    for (int k = 0; k < v.size(); k++) begin
      fo = v[k]; seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (dout_valid === 1'b1) begin
          seen++;
          n_chk++; if (dout !== e[k]) begin n_fail++; $display("FAIL %s_%0d got %h want %h", nm, k, dout, e[k]); end
        end
      end
      n_chk++; if (seen !== 1) begin n_fail++; $display("FAIL %s_%0d_count got %0d want 1", nm, k, seen); end
    end
  endtask

  task automatic test_rounding();
    logic [32:0] v [] = '{33'h0_0000_8000, 33'h0_0000_7FFF, 33'h1_8000_0000};
    logic [15:0] e [] = '{16'h0001, 16'h0000, 16'h8000};
    ready = 1;
    run_table(v, e, "round");
    n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL round_sat got %b want 0", sat_flag); end
  endtask

  task automatic test_saturation();
    logic [32:0] v [] = '{33'h0_FFFF_FFFF, 33'h1_0000_0000};
    logic [15:0] e [] = '{16'h7FFF, 16'h8000};
    clr = 1; tick(); clr = 0;
    run_table(v, e, "sat");
    n_chk++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", sat_flag); end
    n_chk++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL sat_count got %0d want 2", sat_count); end
    clr = 1; tick(); clr = 0;
    n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear_flag got %b want 0", sat_flag); end
    n_chk++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sat_clear_count got %0d want 0", sat_count); end
  endtask

  task automatic test_backpressure();
    ready = 1;
    for (int i = 0; i < 20 && mcnt != 1; i++) tick();
    ready = 0;
    for (int i = 0; i < 40; i++) begin fo = {1'($urandom_range(0, 1)), 32'($urandom)}; tick(); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
    n_chk++; if (sat_flag !== msat) begin n_fail++; $display("FAIL bp_sat got %b want %b", sat_flag, msat); end
    n_chk++; if (sat_count !== 16'(msatn)) begin n_fail++; $display("FAIL bp_sat_count got %0d want %0d", sat_count, msatn); end
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (dout_valid !== 1'b1 || mq.size() == 0 || dout !== mq[0]) begin n_fail++; $display("FAIL bp_drain_%0d got %b/%h want 1/%h", i, dout_valid, dout, mq.size() ? mq[0] : 16'hx); end
      tick();
    end
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", dout_valid); end
  endtask

  task automatic test_full_pushpop();
    int i;
    clr = 1; tick(); clr = 0; ready = 0;
    for (i = 0; i < 100 && !(mq.size() == 4 && mcnt == 0); i++) begin fo = {1'($urandom_range(0, 1)), 32'($urandom)}; tick(); end
    n_chk++; if (i == 100) begin n_fail++; $display("FAIL full_fill timeout got %0d entries want 4", mq.size()); end
    fo = {1'($urandom_range(0, 1)), 32'($urandom)};
    ready = 1; tick(); ready = 0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow got %b want 0", overflow); end
    ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (dout_valid !== 1'b1 || mq.size() == 0 || dout !== mq[0]) begin n_fail++; $display("FAIL full_drain_%0d got %b/%h want 1/%h", k, dout_valid, dout, mq.size() ? mq[0] : 16'hx); end
      tick();
    end
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL full_count got valid %b want 0 after 4 pops", dout_valid); end
  endtask

  task automatic test_gating_reset();
    int i;
    ready = 1; en = 1;
    for (i = 0; i < 20 && mcnt != 0; i++) tick();
    en = 0;
    for (int k = 0; k < 20; k++) begin
      fo = {1'($urandom_range(0, 1)), 32'($urandom)}; tick();
      n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL gate_valid cyc %0d got %b want 0", k, dout_valid); end
    end
    en = 1; ready = 0;
    for (i = 0; i < 100 && !(mq.size() == 2 && mcnt == 3); i++) begin fo = {1'($urandom_range(0, 1)), 32'($urandom)}; tick(); end
    n_chk++; if (i == 100) begin n_fail++; $display("FAIL rst_setup timeout got %0d entries want 2", mq.size()); end
    rst = 1; tick(); rst = 0;
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", dout_valid); end
    n_chk++; if (overflow !== 1'b0 || sat_flag !== 1'b0 || sat_count !== 16'h0) begin n_fail++; $display("FAIL rst_status got %b/%b/%0d want 0/0/0", overflow, sat_flag, sat_count); end
    fo = 33'h0_2000_0000;
    tick();
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_first_enable got %b want 0", dout_valid); end
    tick();
    n_chk++; if (dout_valid !== 1'b1 || dout !== 16'h2000) begin n_fail++; $display("FAIL rst_first_capture got %b/%h want 1/2000", dout_valid, dout); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pushpop();
    test_gating_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
